// File: rtl/divider_pkg.sv
// Shared definitions for the divider: control polarities, iteration count, FSM states and the
// EX-stage operator codes that select DIV / DIVU.
package divider_pkg;

  localparam logic        ResetEnable      = 1'b1;
  localparam logic        StallEnable      = 1'b1;
  localparam int unsigned DivideIterations = 32;

  typedef enum logic [1:0] {
    StIdle,
    StZero,
    StRunning,
    StDone
  } div_state_e;

  localparam logic [3:0] CategoryAlu    = 4'd0;
  localparam logic [3:0] CategoryMul    = 4'd1;
  localparam logic [3:0] CategoryDiv    = 4'd2;
  localparam logic [5:0] OperatorDiv    = 6'd20;
  localparam logic [5:0] OperatorDivu   = 6'd21;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct when read unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/divider.sv
// Multi-cycle restoring divider for the EX stage: one quotient bit per cycle, MSB first,
// with a fast path for a zero divisor and sign correction applied on the final step.
module divider
  import divider_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        signed_enable,
  input  logic        annul,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        ready,
  output logic        stall_request
);

  div_state_e  state_q;
  logic [5:0]  count_q;
  logic [31:0] quo_work_q;   // dividend bits shift out the top, quotient bits shift in below
  logic [31:0] partial_q;
  logic [31:0] divisor_q;
  logic        neg_quot_q;
  logic        neg_rem_q;

  logic [32:0] shifted;
  logic [32:0] trial;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic        quo_bit;

  always_comb begin
    shifted = {partial_q, quo_work_q[31]};
    trial   = shifted - {1'b0, divisor_q};
    quo_bit = ~trial[32];
    if (quo_bit) begin
      rem_next = trial[31:0];
    end else begin
      rem_next = shifted[31:0];
    end
    quo_next = {quo_work_q[30:0], quo_bit};
  end

  assign stall_request = (start && !ready && !annul) ? StallEnable : ~StallEnable;

  always_ff @(posedge clock) begin
    if (reset == ResetEnable) begin
      state_q    <= StIdle;
      count_q    <= '0;
      quo_work_q <= '0;
      partial_q  <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      ready      <= 1'b0;
    end else if (annul) begin
      state_q <= StIdle;
      ready   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state_q <= StZero;
            end else begin
              quo_work_q <= magnitude(dividend, signed_enable);
              divisor_q  <= magnitude(divisor, signed_enable);
              partial_q  <= '0;
              neg_quot_q <= signed_enable && (dividend[31] ^ divisor[31]);
              neg_rem_q  <= signed_enable && dividend[31];
              count_q    <= '0;
              state_q    <= StRunning;
            end
          end
        end
        StZero: begin
          quotient  <= '0;
          remainder <= '0;
          state_q   <= StDone;
        end
        StRunning: begin
          quo_work_q <= quo_next;
          partial_q  <= rem_next;
          count_q    <= count_q + 6'd1;
          if (count_q == 6'(DivideIterations - 1)) begin
            quotient  <= neg_quot_q ? (~quo_next + 32'd1) : quo_next;
            remainder <= neg_rem_q ? (~rem_next + 32'd1) : rem_next;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (start) begin
            ready <= 1'b1;
          end else begin
            ready   <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the divider: latency, signed/unsigned results, zero
// divisor, annul, reset mid-operation and result hold in DONE.
module tb_divider;
  import divider_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_enable = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        stall_request;

  int checks = 0;
  int failures = 0;

  divider dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .signed_enable (signed_enable),
    .annul         (annul),
    .dividend      (dividend),
    .divisor       (divisor),
    .quotient      (quotient),
    .remainder     (remainder),
    .ready         (ready),
    .stall_request (stall_request)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accepts one division, waits for ready, checks latency/results, holds 5 cycles, releases.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_q,
                         input logic [31:0] exp_r);
    int cyc;
    logic stall_ok;
    logic [31:0] hq, hr;
    logic hold_ok;
    signed_enable = sgn;
    dividend = a;
    divisor = b;
    start = 1'b1;
    tick();
    cyc = 0;
    stall_ok = 1'b1;
    // Operands change after acceptance and must be ignored.
    dividend = 32'hDEAD_BEEF;
    divisor = 32'h0000_0003;
    signed_enable = ~sgn;
    while (ready !== 1'b1 && cyc < 40) begin
      if (stall_request !== 1'b1) stall_ok = 1'b0;
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, exp_lat);
    end
    checks++;
    if (!stall_ok) begin
      failures++;
      $display("FAIL %s stall_request: dropped before ready, expected 1 throughout", name);
    end
    checks++;
    if (quotient !== exp_q || remainder !== exp_r) begin
      failures++;
      $display("FAIL %s result: got q=%h r=%h, expected q=%h r=%h", name, quotient, remainder,
               exp_q, exp_r);
    end
    checks++;
    if (stall_request !== 1'b0) begin
      failures++;
      $display("FAIL %s stall_when_ready: got %b, expected 0", name, stall_request);
    end
    hq = quotient;
    hr = remainder;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ready !== 1'b1 || quotient !== exp_q || remainder !== exp_r) hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      failures++;
      $display("FAIL %s hold: outputs unstable in DONE, last q=%h r=%h ready=%b, expected q=%h r=%h ready=1",
               name, quotient, remainder, ready, hq, hr);
    end
    start = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b0 || dut.state_q !== StIdle) begin
      failures++;
      $display("FAIL %s release: got ready=%b state=%0d, expected ready=0 state=%0d", name, ready,
               dut.state_q, StIdle);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    annul = 1'b1;
    divisor = 32'd5;
    dividend = 32'd50;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (quotient !== '0 || remainder !== '0 || ready !== 1'b0 || dut.state_q !== StIdle) begin
      failures++;
      $display("FAIL reset_state: got q=%h r=%h ready=%b state=%0d, expected all 0 / idle",
               quotient, remainder, ready, dut.state_q);
    end
    start = 1'b0;
    annul = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("udiv_big", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 33, 32'h0000_FFFF, 32'h0000_FFFF);
  endtask

  task automatic test_signed();
    run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("sdiv_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
  endtask

  task automatic test_zero_divisor();
    run_div("div_zero", 1'b0, 32'h1234_5678, 32'd0, 2, 32'd0, 32'd0);
  endtask

  task automatic test_annul();
    logic seen_ready;
    logic [31:0] pq, pr;
    pq = quotient;
    pr = remainder;
    signed_enable = 1'b0;
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) tick();
    annul = 1'b1;
    #1;
    checks++;
    if (stall_request !== 1'b0) begin
      failures++;
      $display("FAIL annul_stall: got %b, expected 0", stall_request);
    end
    tick();
    checks++;
    if (dut.state_q !== StIdle || ready !== 1'b0 || quotient !== pq || remainder !== pr) begin
      failures++;
      $display("FAIL annul_idle: got state=%0d ready=%b q=%h r=%h, expected idle ready=0 q=%h r=%h",
               dut.state_q, ready, quotient, remainder, pq, pr);
    end
    annul = 1'b0;
    start = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready !== 1'b0) seen_ready = 1'b1;
    end
    checks++;
    if (seen_ready) begin
      failures++;
      $display("FAIL annul_no_ready: ready rose after annul, expected 0");
    end
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);
  endtask

  task automatic test_reset_midop();
    logic seen_ready;
    signed_enable = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd3;
    start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (quotient !== '0 || remainder !== '0 || ready !== 1'b0 || dut.state_q !== StIdle) begin
      failures++;
      $display("FAIL reset_midop: got q=%h r=%h ready=%b state=%0d, expected all 0 / idle",
               quotient, remainder, ready, dut.state_q);
    end
    reset = 1'b0;
    start = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready !== 1'b0) seen_ready = 1'b1;
    end
    checks++;
    if (seen_ready) begin
      failures++;
      $display("FAIL reset_no_ready: ready rose after reset release, expected 0");
    end
  endtask

  task automatic test_start_dropped();
    signed_enable = 1'b0;
    dividend = 32'd1000;
    divisor = 32'd10;
    start = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (quotient !== 32'd100 || remainder !== 32'd0 || ready !== 1'b0 ||
        dut.state_q !== StIdle) begin
      failures++;
      $display("FAIL start_dropped: got q=%h r=%h ready=%b state=%0d, expected q=64 r=0 ready=0 idle",
               quotient, remainder, ready, dut.state_q);
    end
  endtask

  task automatic test_back_to_back();
    run_div("b2b_a", 1'b0, 32'd77, 32'd11, 33, 32'd7, 32'd0);
    run_div("b2b_b", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 32'hFFFF_FFFE);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero_divisor();
    test_annul();
    test_reset_midop();
    test_start_dropped();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high (`RESET_ENABLE); sampled on rising clock edge only.
REQ-003 SHALL have port: start  input  1  EX-stage request to divide; held high until result consumed.
REQ-004 SHALL have port: signed_enable  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start in IDLE.
REQ-005 SHALL have port: annul  input  1  cancels the operation in flight (exception/flush).
REQ-006 SHALL have port: dividend  input  32  operand A from ID/EX latch; sampled with start in IDLE.
REQ-007 SHALL have port: divisor  input  32  operand B from ID/EX latch; sampled with start in IDLE.
REQ-008 SHALL have port: quotient  output  32  result quotient, valid while ready=1.
REQ-009 SHALL have port: remainder  output  32  result remainder, valid while ready=1.
REQ-010 SHALL have port: ready  output  1  result valid, registered.
REQ-011 SHALL have port: stall_request  output  1  combinational: start=1 and ready=0 and annul=0; drives the EX stall bit.

Function
REQ-012 SHALL implement four states: IDLE, ZERO, RUNNING, DONE.
REQ-013 In IDLE with start=1, annul=0 and divisor=0, SHALL go to ZERO.
REQ-014 In IDLE with start=1, annul=0 and divisor!=0, SHALL latch operands, signed_enable and the signs, clear the iteration counter, and go to RUNNING.
REQ-015 When signed_enable=1, SHALL divide magnitudes; quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
REQ-016 In RUNNING, SHALL perform one restoring shift-subtract step per cycle: 33-bit trial subtract, one quotient bit per step, MSB first.
REQ-017 After exactly 32 RUNNING cycles, SHALL apply the sign correction, register quotient and remainder, and go to DONE.
REQ-018 In ZERO, SHALL register quotient=0 and remainder=0 and go to DONE next cycle.
REQ-019 In DONE, SHALL hold ready=1 and the outputs stable while start=1; with start=0, SHALL go to IDLE and drive ready=0.
REQ-020 Latency: ready SHALL rise 33 cycles after the edge that accepted start (nonzero divisor), 2 cycles after it for a zero divisor.
REQ-021 annul=1 in any state SHALL force IDLE on the next edge, ready=0, outputs unchanged; annul has priority over start.
REQ-022 Operand changes while not in IDLE SHALL be ignored.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0, with no special-casing beyond the magnitude path.
REQ-024 start=0 in RUNNING or ZERO without annul SHALL NOT abort the operation; it completes to DONE, then returns to IDLE.

Reset
REQ-025 reset=1 SHALL force IDLE, counter=0, quotient=0, remainder=0, ready=0 on the next edge, overriding annul and start.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no ready pulse SHALL follow reset release unless a new start is accepted.

Structure
REQ-027 State encodings, DIVIDE_ITERATIONS=32, and the RESET_ENABLE / STALL_ENABLE defines SHALL live in the shared defines file alongside the OPERATOR_* / CATEGORY_* definitions.
REQ-028 SHALL be a single module with no sub-modules; it is instantiated by the EX stage, which maps OPERATOR_DIV / OPERATOR_DIVU to start and signed_enable.

Verification
REQ-029 Unsigned 100 / 7, start held -> ready at cycle 33, quotient=14, remainder=2, stall_request=1 for cycles 0..32.
REQ-030 Signed 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF at cycle 33; signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-031 Divisor 0 with dividend 0x12345678 -> ready at cycle 2, quotient=0, remainder=0.
REQ-032 annul at cycle 10 of RUNNING -> IDLE at cycle 11, ready never rises; a new 9 / 3 start -> quotient=3, remainder=0 after 33 cycles.
REQ-033 reset at cycle 20 of RUNNING -> all outputs 0, state IDLE; start held in DONE for 5 cycles -> outputs stable; start dropped -> ready=0 next cycle.
